// File: rtl/enc8to3_arbiter.sv
// Registered 8-to-3 encoder/arbiter with Ack handshake and optional hold timeout.
// Build macro ARB_ROUND_ROBIN_EN selects rotating priority; otherwise fixed lowest-index priority.
module enc8to3_arbiter #(
    parameter int unsigned HOLD_MAX = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       E,
    input  logic [0:7] Req,
    input  logic       Ack,
    output logic [2:0] W,
    output logic       Valid,
    output logic [0:7] Grant,
    output logic       Timeout
);

    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NREQ   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] ptr;
    logic [CODE_W-1:0] ptr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CODE_W-1:0] w_nxt;
    logic              valid_nxt;
    logic [0:7]        grant_nxt;
    logic              timeout_nxt;

    logic [CODE_W-1:0] sel;
    logic [0:7]        sel_onehot;
    logic              any_req;
    logic              hold_expired;

    assign any_req      = |Req;
    assign hold_expired = (HOLD_MAX != 0) && (cnt == HOLD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    // Scan starts at the slot after the retiring grant so a back-to-back grant already rotates.
    logic [CODE_W-1:0] scan_start;
    logic [CODE_W-1:0] scan_idx;
    logic              found;

    assign scan_start = (state == GRANT) ? W + CODE_W'(1) : ptr;

    always_comb begin
        sel      = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = scan_start + CODE_W'(k);
            if (!found && Req[scan_idx]) begin
                sel   = scan_idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: lowest asserted index wins.
    always_comb begin
        sel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (Req[i]) begin
                sel = CODE_W'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    // State register and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            W       <= '0;
            Valid   <= 1'b0;
            Grant   <= '0;
            Timeout <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            W       <= w_nxt;
            Valid   <= valid_nxt;
            Grant   <= grant_nxt;
            Timeout <= timeout_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (E && any_req) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (Ack) begin
                    state_nxt = (E && any_req) ? GRANT : IDLE;
                end else if (hold_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        w_nxt       = W;
        valid_nxt   = 1'b0;
        grant_nxt   = '0;
        timeout_nxt = 1'b0;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        unique case (state)
            IDLE: begin
                if (E && any_req) begin
                    w_nxt     = sel;
                    valid_nxt = 1'b1;
                    grant_nxt = sel_onehot;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (Ack) begin
                    ptr_nxt = W + CODE_W'(1);
                    if (E && any_req) begin
                        w_nxt     = sel;
                        valid_nxt = 1'b1;
                        grant_nxt = sel_onehot;
                        cnt_nxt   = '0;
                    end
                end else if (hold_expired) begin
                    ptr_nxt     = W + CODE_W'(1);
                    timeout_nxt = 1'b1;
                end else begin
                    valid_nxt = 1'b1;
                    grant_nxt = Grant;
                    cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                end
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_enc8to3_arbiter.sv
// Scoreboard bench for enc8to3_arbiter: behavioural model predicts every cycle's outputs.
module tb_enc8to3_arbiter;

    localparam int unsigned HOLD = 4;

    typedef struct packed {
        logic [2:0] w;
        logic       valid;
        logic [0:7] grant;
        logic       timeout;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [0:7] req;
    logic       ack;
    logic [2:0] w;
    logic       valid;
    logic [0:7] grant;
    logic       timeout;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    // Model state
    bit m_busy;
    int m_w;
    int m_age;
    int m_ptr;
    bit m_to;

    enc8to3_arbiter #(.HOLD_MAX(HOLD)) dut (
        .Clock  (clk),
        .Reset  (rst),
        .E      (en),
        .Req    (req),
        .Ack    (ack),
        .W      (w),
        .Valid  (valid),
        .Grant  (grant),
        .Timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pick(input logic [0:7] q, input int p);
        int r;
        r = 0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 7; k >= 0; k--) begin
            if (q[(p + k) % 8]) r = (p + k) % 8;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (q[i]) r = i;
        end
`endif
        return r;
    endfunction

    task automatic model_step(input logic r, input logic e_i, input logic [0:7] q, input logic a);
        m_to = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_w    = 0;
            m_age  = 0;
            m_ptr  = 0;
        end else if (m_busy) begin
            if (a) begin
                m_ptr = (m_w + 1) % 8;
                if (e_i && q != 8'b0) begin
                    m_w   = pick(q, m_ptr);
                    m_age = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (HOLD != 0 && m_age == HOLD - 1) begin
                m_busy = 1'b0;
                m_ptr  = (m_w + 1) % 8;
                m_to   = 1'b1;
            end else if (m_age < 255) begin
                m_age = m_age + 1;
            end
        end else if (e_i && q != 8'b0) begin
            m_busy = 1'b1;
            m_w    = pick(q, m_ptr);
            m_age  = 0;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic e_i, input logic [0:7] q, input logic a);
        exp_t e;
        @(negedge clk);
        rst = r;
        en  = e_i;
        req = q;
        ack = a;
        model_step(r, e_i, q, a);
        e.w       = 3'(m_w);
        e.valid   = m_busy;
        e.grant   = '0;
        if (m_busy) e.grant[m_w] = 1'b1;
        e.timeout = m_to;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {w, valid, grant, timeout};
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL outputs @%0t: got W=%0d Valid=%b Grant=%b Timeout=%b, want W=%0d Valid=%b Grant=%b Timeout=%b",
                             $time, act.w, act.valid, act.grant, act.timeout,
                             e.w, e.valid, e.grant, e.timeout);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        ack = 1'b0;
        m_busy = 1'b0;
        m_w = 0;
        m_age = 0;
        m_ptr = 0;
        m_to = 1'b0;

        // Reset with all requests asserted
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);

        // Single request Req[2], hold, then ack
        step(1'b0, 1'b1, 8'b00100000, 1'b0);
        step(1'b0, 1'b1, 8'b00100000, 1'b0);
        step(1'b0, 1'b1, 8'b00100000, 1'b0);
        step(1'b0, 1'b1, 8'b00000000, 1'b1);
        step(1'b0, 1'b1, 8'b00000000, 1'b0);

        // Arbitration between Req[0] and Req[7], ack every grant
        step(1'b1, 1'b0, 8'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'b10000001, 1'b1);
        step(1'b0, 1'b0, 8'b0, 1'b1);

        // Timeout with Req[5]; then ack landing in the 4th held cycle
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i == 0) ? 8'b00000100 : 8'b0, 1'b0);
        step(1'b0, 1'b1, 8'b00000100, 1'b0);
        step(1'b0, 1'b1, 8'b0, 1'b0);
        step(1'b0, 1'b1, 8'b0, 1'b0);
        step(1'b0, 1'b1, 8'b0, 1'b0);
        step(1'b0, 1'b1, 8'b0, 1'b1);
        step(1'b0, 1'b1, 8'b0, 1'b0);

        // Enable drop mid-grant, then reset mid-grant
        step(1'b0, 1'b1, 8'b00010000, 1'b0);
        step(1'b0, 1'b0, 8'b00010000, 1'b0);
        step(1'b0, 1'b0, 8'b00010000, 1'b1);
        step(1'b0, 1'b0, 8'b00010000, 1'b0);
        step(1'b0, 1'b1, 8'b00010000, 1'b0);
        step(1'b1, 1'b1, 8'b00010000, 1'b0);
        step(1'b0, 1'b0, 8'b0, 1'b0);

        // Pointer wrap: grant 7, ack with Req[0],Req[1]
        step(1'b0, 1'b1, 8'b00000001, 1'b0);
        step(1'b0, 1'b1, 8'b11000000, 1'b1);
        step(1'b0, 1'b1, 8'b11000000, 1'b1);
        step(1'b0, 1'b0, 8'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic       r_r;
            logic       r_e;
            logic [0:7] r_q;
            logic       r_a;
            r_r = ($urandom_range(0, 99) == 0);
            r_e = ($urandom_range(0, 99) < 85);
            r_q = ($urandom_range(0, 4) == 0) ? 8'b0 : 8'($urandom);
            r_a = ($urandom_range(0, 99) < 35);
            step(r_r, r_e, r_q, r_a);
        end
        step(1'b0, 1'b0, 8'b0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
